// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and helpers for the alu_seq multi-cycle ALU.
// Optional feature macro: ALU_DIV_EN (iterative divider, opcode 11).
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_ROL   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_MAX   = 4'd12;
  localparam logic [3:0] OP_MIN   = 4'd13;
  localparam logic [3:0] OP_ILL14 = 4'd14;
  localparam logic [3:0] OP_ILL15 = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Ops that run through the shared multi-cycle datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared shift-add multiplier / restoring divider, one step per clock.
// Divider half present only when ALU_DIV_EN is defined.
module alu_seq_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_a_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_nxt_o
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_nxt_s;

`ifdef ALU_DIV_EN
  // Divider keeps {remainder, quotient} in the accumulator; quotient bits enter at the bottom.
  logic               mode_q;
  logic [WIDTH:0]     div_t_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] div_nxt_s;
`else
  logic               unused_mode_s;
  assign unused_mode_s = mode_i;
`endif

  // Next accumulator value for the current step.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_nxt_s = {mul_sum_s, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_t_s    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff_s = div_t_s - {1'b0, m_q};
    if (div_diff_s[WIDTH]) begin
      div_nxt_s = {div_t_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_nxt_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    acc_nxt_o = mode_q ? div_nxt_s : mul_nxt_s;
`else
    acc_nxt_o = mul_nxt_s;
`endif
  end

  // Operand load and per-step accumulator update.
  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      acc_q <= {(2*WIDTH){1'b0}};
      m_q   <= {WIDTH{1'b0}};
`ifdef ALU_DIV_EN
      mode_q <= 1'b0;
`endif
    end else if (load_i) begin
`ifdef ALU_DIV_EN
      mode_q <= mode_i;
      if (mode_i) begin
        acc_q <= {{WIDTH{1'b0}}, a_i};
        m_q   <= b_i;
      end else begin
        acc_q <= {{WIDTH{1'b0}}, b_i};
        m_q   <= a_i;
      end
`else
      acc_q <= {{WIDTH{1'b0}}, b_i};
      m_q   <= a_i;
`endif
    end else if (step_i) begin
      acc_q <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake; MUL (and DIV when
// ALU_DIV_EN is defined) iterate WIDTH cycles, everything else takes one.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_a_n,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  input  logic [3:0]         opcode,
  input  logic               start,
  output logic [2*WIDTH-1:0] out,
  output logic               carry_flag,
  output logic               zero_flag,
  output logic               err_flag,
  output logic               busy,
  output logic               done_flag
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [SHW-1:0]     shamt_s;
  logic [WIDTH:0]     sum_s, diff_s, shl_s, shr_s;
  logic [2*WIDTH-1:0] rol_s, sc_res_s, fin_res_s, iter_acc_nxt_s;
  logic [WIDTH-1:0]   sra_s;
  logic               sc_carry_s, sc_err_s, fin_carry_s, fin_err_s;
  logic               iter_run_s, iter_load_s, iter_step_s, fin_s;

  assign shamt_s = b_q[SHW-1:0];
  assign sum_s   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_s  = {1'b0, a_q} - {1'b0, b_q};
  assign shl_s   = {1'b0, a_q} << shamt_s;
  assign shr_s   = {a_q, 1'b0} >> shamt_s;
  assign sra_s   = $signed(a_q) >>> shamt_s;
  assign rol_s   = {a_q, a_q} << shamt_s;

  // Divide-by-zero short-circuits to a single-cycle error result.
  assign iter_run_s = is_iter_op(op_q) && ((op_q != OP_DIV) || (b_q != {WIDTH{1'b0}}));

  // Single-cycle result and flags for the latched operation.
  always_comb begin
    sc_res_s   = {(2*WIDTH){1'b0}};
    sc_carry_s = 1'b0;
    sc_err_s   = 1'b0;
    case (op_q)
      OP_ADD: begin
        sc_res_s   = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
        sc_carry_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        sc_res_s   = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
        sc_carry_s = diff_s[WIDTH];
      end
      OP_AND: sc_res_s = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  sc_res_s = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: sc_res_s = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_NOT: sc_res_s = {{WIDTH{1'b0}}, ~a_q};
      OP_SHL: begin
        sc_res_s   = {{WIDTH{1'b0}}, shl_s[WIDTH-1:0]};
        sc_carry_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        sc_res_s   = {{WIDTH{1'b0}}, shr_s[WIDTH:1]};
        sc_carry_s = shr_s[0];
      end
      OP_SRA: begin
        sc_res_s   = {{WIDTH{1'b0}}, sra_s};
        sc_carry_s = shr_s[0];
      end
      OP_ROL: sc_res_s = {{WIDTH{1'b0}}, rol_s[2*WIDTH-1:WIDTH]};
      OP_MAX: sc_res_s = {{WIDTH{1'b0}}, (a_q > b_q) ? a_q : b_q};
      OP_MIN: sc_res_s = {{WIDTH{1'b0}}, (a_q < b_q) ? a_q : b_q};
`ifdef ALU_DIV_EN
      OP_DIV: begin
        sc_res_s = {(2*WIDTH){1'b1}};
        sc_err_s = 1'b1;
      end
`endif
      default: begin
        sc_res_s = {(2*WIDTH){1'b0}};
        sc_err_s = 1'b1;
      end
    endcase
  end

  // FSM next state, operand latch and completion update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    iter_load_s = 1'b0;
    iter_step_s = 1'b0;
    fin_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d         = dataa;
          b_d         = datab;
          op_d        = opcode;
          cnt_d       = {SHW{1'b0}};
          busy_d      = 1'b1;
          iter_load_s = is_iter_op(opcode);
          state_d     = ST_EXEC;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (iter_run_s) begin
          iter_step_s = 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            fin_s = 1'b1;
          end else begin
            cnt_d = cnt_q + SHW'(1);
          end
        end else begin
          fin_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    fin_res_s   = iter_run_s ? iter_acc_nxt_s : sc_res_s;
    fin_carry_s = iter_run_s ? 1'b0 : sc_carry_s;
    fin_err_s   = iter_run_s ? 1'b0 : sc_err_s;
    if (fin_s) begin
      out_d   = fin_res_s;
      carry_d = fin_carry_s;
      zero_d  = (fin_res_s == {(2*WIDTH){1'b0}});
      err_d   = fin_err_s;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      cnt_d   = {SHW{1'b0}};
      state_d = ST_IDLE;
    end else begin
      done_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= 4'd0;
      cnt_q   <= {SHW{1'b0}};
      out_q   <= {(2*WIDTH){1'b0}};
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .reset_a_n (reset_a_n),
    .load_i    (iter_load_s),
    .step_i    (iter_step_s),
    .mode_i    (opcode == OP_DIV),
    .a_i       (dataa),
    .b_i       (datab),
    .acc_nxt_o (iter_acc_nxt_s)
  );

  assign out        = out_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign err_flag   = err_q;
  assign busy       = busy_q;
  assign done_flag  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16); DIV expectations
// follow whether ALU_DIV_EN is defined for the build.
module tb_alu_seq;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               reset_a_n;
  logic [WIDTH-1:0]   dataa, datab;
  logic [3:0]         opcode;
  logic               start;
  logic [2*WIDTH-1:0] out;
  logic               carry_flag, zero_flag, err_flag, busy, done_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_a_n  (reset_a_n),
    .dataa      (dataa),
    .datab      (datab),
    .opcode     (opcode),
    .start      (start),
    .out        (out),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .err_flag   (err_flag),
    .busy       (busy),
    .done_flag  (done_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_out"},  64'(out),        64'h0);
    check({tag, "_c"},    64'(carry_flag), 64'h0);
    check({tag, "_z"},    64'(zero_flag),  64'h0);
    check({tag, "_e"},    64'(err_flag),   64'h0);
    check({tag, "_busy"}, 64'(busy),       64'h0);
    check({tag, "_done"}, 64'(done_flag),  64'h0);
  endtask

  // Launch one op, optionally pulse start while busy, then check result and timing.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp_out, input logic exp_c,
                        input logic exp_z, input logic exp_e, input int exp_lat,
                        input int pulse_at);
    int n;
    @(negedge clk);
    dataa = a; datab = b; opcode = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    check({tag, "_busy_on"}, 64'(busy), 64'h1);
    while (!done_flag && n < 64) begin
      if (n == pulse_at) begin
        dataa = 16'h0001; datab = 16'h0001; opcode = 4'd0; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, "_lat"},      64'(n),          64'(exp_lat));
    check({tag, "_out"},      64'(out),        64'(exp_out));
    check({tag, "_c"},        64'(carry_flag), 64'(exp_c));
    check({tag, "_z"},        64'(zero_flag),  64'(exp_z));
    check({tag, "_e"},        64'(err_flag),   64'(exp_e));
    check({tag, "_busy_off"}, 64'(busy),       64'h0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done_flag), 64'h0);
    check({tag, "_hold"},       64'(out),       64'(exp_out));
  endtask

  initial begin
    reset_a_n = 1'b0;
    dataa = 16'h0; datab = 16'h0; opcode = 4'd0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_held");
    reset_a_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_rel");

    run_op("add",   4'd0,  16'h0008, 16'h0002, 32'h0000000A, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("add_c", 4'd0,  16'hFFFF, 16'h0001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1, -1);
    run_op("sub",   4'd1,  16'h0002, 16'h0008, 32'h0000FFFA, 1'b1, 1'b0, 1'b0, 1, -1);
    run_op("and",   4'd2,  16'hF0F0, 16'h3C3C, 32'h00003030, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("xor",   4'd4,  16'hF0F0, 16'h3C3C, 32'h0000CCCC, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("not",   4'd5,  16'h00FF, 16'h0000, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("shl",   4'd6,  16'h8001, 16'h0001, 32'h00000002, 1'b1, 1'b0, 1'b0, 1, -1);
    run_op("mul",   4'd10, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b0, 16, 5);
    run_op("shr",   4'd7,  16'h0003, 16'h0001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1, -1);
    run_op("shl0",  4'd6,  16'h8001, 16'h0000, 32'h00008001, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("sra",   4'd8,  16'h8000, 16'h0003, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("rol",   4'd9,  16'h8001, 16'h0004, 32'h00000018, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("mul2",  4'd10, 16'h1234, 16'h0010, 32'h00012340, 1'b0, 1'b0, 1'b0, 16, -1);
    run_op("max",   4'd12, 16'h0005, 16'h0009, 32'h00000009, 1'b0, 1'b0, 1'b0, 1, -1);
    run_op("min",   4'd13, 16'h0005, 16'h0009, 32'h00000005, 1'b0, 1'b0, 1'b0, 1, -1);
`ifdef ALU_DIV_EN
    run_op("div",   4'd11, 16'h0009, 16'h0002, 32'h00010004, 1'b0, 1'b0, 1'b0, 16, -1);
    run_op("div0",  4'd11, 16'h0009, 16'h0000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1, -1);
`else
    run_op("div",   4'd11, 16'h0009, 16'h0002, 32'h00000000, 1'b0, 1'b1, 1'b1, 1, -1);
    run_op("div0",  4'd11, 16'h0009, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1, -1);
`endif
    run_op("ill15", 4'd15, 16'h0001, 16'h0001, 32'h00000000, 1'b0, 1'b1, 1'b1, 1, -1);
    run_op("errclr", 4'd0, 16'h0001, 16'h0001, 32'h00000002, 1'b0, 1'b0, 1'b0, 1, -1);

    // Reset in the middle of a multiply: everything clears at once, no done pulse.
    @(negedge clk);
    dataa = 16'hFFFF; datab = 16'hFFFF; opcode = 4'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset_a_n = 1'b0;
    #1 check_idle_zero("mid_reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_flag) check("mid_reset_nodone", 64'(done_flag), 64'h0);
    end
    reset_a_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_flag || busy) check("post_reset_quiet", 64'({done_flag, busy}), 64'h0);
    end
    run_op("post_add", 4'd0, 16'h0003, 16'h0004, 32'h00000007, 1'b0, 1'b0, 1'b0, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
